// File: rtl/alu_mul_seq.sv
// Shift-and-add unsigned multiplier that borrows the shared arithmetic unit as its adder.
// One ADD is issued per iteration and the carry is folded back into the accumulator MSB.
//
// state | meaning
// IDLE  | waiting for start, product held on P
// CALC  | one shift-and-add iteration per cycle, DATA_WIDTH iterations
// DONE  | single-cycle done pulse, start ignored
module alu_mul_seq #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   A,
  input  logic [DATA_WIDTH-1:0]   B,
  output logic                    busy,
  output logic                    done,
  output logic [2*DATA_WIDTH-1:0] P,
  output logic [DATA_WIDTH-1:0]   au_A,
  output logic [DATA_WIDTH-1:0]   au_B,
  output logic [2:0]              au_opcode,
  input  logic [DATA_WIDTH-1:0]   au_S,
  input  logic                    au_Cout
);

  localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] mcand, mcand_nxt;
  logic [DATA_WIDTH-1:0] acc, acc_nxt;
  logic [DATA_WIDTH-1:0] mq, mq_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic [DATA_WIDTH-1:0] sum_s;
  logic                  sum_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      mcand <= '0;
      acc   <= '0;
      mq    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      mcand <= mcand_nxt;
      acc   <= acc_nxt;
      mq    <= mq_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mcand_nxt = mcand;
    acc_nxt   = acc;
    mq_nxt    = mq;
    cnt_nxt   = cnt;
    sum_s     = acc;
    sum_c     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          mcand_nxt = A;
          mq_nxt    = B;
          acc_nxt   = '0;
          cnt_nxt   = '0;
          state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        // Only take the AU result when the current multiplier bit is set.
        if (mq[0]) begin
          sum_s = au_S;
          sum_c = au_Cout;
        end
        acc_nxt = {sum_c, sum_s[DATA_WIDTH-1:1]};
        mq_nxt  = {sum_s[0], mq[DATA_WIDTH-1:1]};
        cnt_nxt = cnt + CW'(1);
        if (cnt == LAST) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign P         = {acc, mq};
  assign au_A      = acc;
  assign au_B      = mcand;
  assign au_opcode = 3'b000;

endmodule
